booth_divider_signed: RTL and testbench



---
 rtl/booth_divider_signed.sv | 126 ++++++++++++
 tb/tb_booth_divider_signed.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider_signed.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per cycle, signs applied in a final fix-up cycle.
module booth_divider_signed #(
  parameter int DIVIDEND_W    = 8,
  parameter int DIVISOR_W     = 4,
  parameter int FINISH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  done,
  output logic                  div_zero,
  output logic                  ovf,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int FIN_W = (FINISH_CYCLES > 1) ? $clog2(FINISH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CAL    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FIN_W-1:0]      fin_cnt_q;
  logic [DIVIDEND_W-1:0] quo_q, quo_d, dvd_mag;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_mag_q, dvs_mag;
  logic                  dvd_neg_q, dvs_neg_q;
  logic [DIVISOR_W+1:0]  rem_shift, trial;
  logic                  borrow, neg_quo;

  assign dbg_state_o = state_q;

  // quo_q starts as the dividend magnitude and fills with quotient bits as
  // the dividend bits shift out of its top into the partial remainder.
  always_comb begin
    rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
    trial     = rem_shift - {2'b00, dvs_mag_q};
    borrow    = trial[DIVISOR_W+1];
    rem_d     = borrow ? rem_shift[DIVISOR_W:0] : trial[DIVISOR_W:0];
    quo_d     = {quo_q[DIVIDEND_W-2:0], ~borrow};
    dvd_mag   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    dvs_mag   = divisor[DIVISOR_W-1] ? -divisor : divisor;
    neg_quo   = dvd_neg_q ^ dvs_neg_q;
  end

  // Handshake: start is a request sampled only in WAIT; the operands present
  // at that edge are latched and later input changes are ignored. done is
  // high exactly while in FINISH, and q/r/div_zero/ovf are valid while done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      fin_cnt_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_mag_q <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      q         <= '0;
      r         <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          q        <= '0;
          r        <= '0;
          div_zero <= 1'b0;
          ovf      <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            dvd_neg_q <= dividend[DIVIDEND_W-1];
            dvs_neg_q <= divisor[DIVISOR_W-1];
            quo_q     <= dvd_mag;
            dvs_mag_q <= dvs_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              done      <= 1'b1;
              fin_cnt_q <= '0;
              state_q   <= S_FINISH;
            end else begin
              state_q <= S_CAL;
            end
          end
        end
        S_CAL: begin
          if (cnt_q == CNT_W'(DIVIDEND_W)) begin
            // Truncating division: remainder follows the dividend's sign.
            q         <= neg_quo ? -quo_q : quo_q;
            r         <= dvd_neg_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
            ovf       <= ~neg_quo & quo_q[DIVIDEND_W-1];
            done      <= 1'b1;
            fin_cnt_q <= '0;
            state_q   <= S_FINISH;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FINISH: begin
          if (fin_cnt_q == FIN_W'(FINISH_CYCLES - 1)) begin
            done    <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            fin_cnt_q <= fin_cnt_q + FIN_W'(1);
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_signed.sv
// Bench for booth_divider_signed: random and directed divisions checked every
// cycle against a latency-window model built on plain signed / and %.
module tb_booth_divider_signed;

  localparam int DIVIDEND_W    = 8;
  localparam int DIVISOR_W     = 4;
  localparam int FINISH_CYCLES = 2;
  localparam int EW            = DIVIDEND_W + DIVISOR_W + 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [DIVIDEND_W-1:0] dividend = '0;
  logic [DIVISOR_W-1:0]  divisor = '0;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0]  r;
  logic                  done, div_zero, ovf;
  logic [1:0]            dbg_state;

  int checks = 0;
  int failures = 0;

  booth_divider_signed #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W(DIVISOR_W),
    .FINISH_CYCLES(FINISH_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .q(q),
    .r(r),
    .done(done),
    .div_zero(div_zero),
    .ovf(ovf),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  int cyc = 0;
  int win_s = -100;
  int win_e = -100;
  int free_cyc = 0;
  int sa, sb, qi, ri;
  logic [EW-1:0] e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      win_s = -100;
      win_e = -100;
      free_cyc = 0;
    end else begin
      cyc++;
      if (start && cyc >= free_cyc) begin
        sa = int'($signed(dividend));
        sb = int'($signed(divisor));
        if (sb == 0) begin
          e = {{DIVIDEND_W{1'b0}}, {DIVISOR_W{1'b0}}, 1'b1, 1'b0};
          win_s = cyc;
        end else begin
          qi = sa / sb;
          ri = sa % sb;
          e = {qi[DIVIDEND_W-1:0], ri[DIVISOR_W-1:0], 1'b0, (qi > 127 || qi < -128)};
          win_s = cyc + DIVIDEND_W + 1;
        end
        exp_q.push_back(e);
        win_e = win_s + FINISH_CYCLES - 1;
        free_cyc = win_e + 2;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc >= win_s && cyc <= win_e) begin
        chk("done_in_window", {31'd0, done}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL exp_queue: actual=empty required=entry at %0t", $time);
        end else begin
          chk("result", {18'd0, q, r, div_zero, ovf}, {18'd0, exp_q[0]});
        end
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
        if (cyc == win_e + 1) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          chk("outputs_idle", {18'd0, q, r, div_zero, ovf}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input logic level, input string name);
    int n = 0;
    while (done !== level && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== level) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=%0b required=%0b", name, done, level);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic lit,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edz, input logic eovf, input string name);
    int n;
    int held;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (!done && n < 40) begin
      dividend = 8'($urandom_range(0, 255));
      divisor = 4'($urandom_range(0, 15));
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=no_done required=done", name);
      return;
    end
    if (lit) begin
      chk({name, "_latency"}, n, (b == 4'd0) ? 1 : DIVIDEND_W + 2);
      chk({name, "_q"}, {24'd0, q}, {24'd0, eq});
      chk({name, "_r"}, {28'd0, r}, {28'd0, er});
      chk({name, "_flags"}, {30'd0, div_zero, ovf}, {30'd0, edz, eovf});
    end
    held = 0;
    while (done && held < 10) begin
      held++;
      @(negedge clk);
    end
    @(negedge clk);
    if (lit) begin
      chk({name, "_hold"}, held, FINISH_CYCLES);
      chk({name, "_cleared"}, {20'd0, q, r}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, q == 8'd0, r == 4'd0, done, div_zero, ovf}, {27'd0, 1'b1, 1'b1, 3'b000});
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd56,  4'd7,  1'b1, 8'd8,   4'd0,  1'b0, 1'b0, "d56_7");
    run_op(8'hC7,  4'd7,  1'b1, 8'hF8,  4'hF,  1'b0, 1'b0, "dm57_7");
    run_op(8'd57,  4'h8,  1'b1, 8'hF9,  4'd1,  1'b0, 1'b0, "d57_m8");
    run_op(8'hC7,  4'h8,  1'b1, 8'd7,   4'hF,  1'b0, 1'b0, "dm57_m8");
    run_op(8'd5,   4'd7,  1'b1, 8'd0,   4'd5,  1'b0, 1'b0, "d5_7");
    run_op(8'h80,  4'd1,  1'b1, 8'h80,  4'd0,  1'b0, 1'b0, "dm128_1");
    run_op(8'h80,  4'hF,  1'b1, 8'h80,  4'd0,  1'b0, 1'b1, "dm128_m1");
    run_op(8'd100, 4'd0,  1'b1, 8'd0,   4'd0,  1'b1, 1'b0, "d100_0");

    // Reset in the middle of CAL.
    start = 1'b1; dividend = 8'd56; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_cal_outputs", {29'd0, q == 8'd0, r == 4'd0, done}, {29'd0, 1'b1, 1'b1, 1'b0});
    chk("rst_cal_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd35, 4'd5, 1'b1, 8'd7, 4'd0, 1'b0, 1'b0, "d35_5");

    // Reset while results are being presented.
    start = 1'b1; dividend = 8'd56; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, "rst_fin");
    chk("rst_fin_pre_q", {24'd0, q}, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("rst_fin_outputs", {29'd0, q == 8'd0, r == 4'd0, done}, {29'd0, 1'b1, 1'b1, 1'b0});
    chk("rst_fin_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start pulses during CAL and FINISH are ignored; held start is accepted in WAIT.
    start = 1'b1; dividend = 8'd56; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, "ign_first");
    chk("ign_q", {24'd0, q}, 32'd8);
    chk("ign_r", {28'd0, r}, 32'd0);
    start = 1'b1; dividend = 8'd9; divisor = 4'd3;
    wait_done(1'b0, "ign_fall");
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, "held_start");
    chk("held_q", {24'd0, q}, 32'd3);
    chk("held_r", {28'd0, r}, 32'd0);
    wait_done(1'b0, "held_fall");
    @(negedge clk);

    // Randomized operations with operand churn while busy.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      run_op(a, b, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
